// File: rtl/hub75_pkg.sv
// Shared HUB75 definitions: panel geometry defaults, packed pixel field order
// and the frame-buffer control states. The panel driver uses the same package.
package hub75_pkg;

   localparam int HUB75_WIDTH      = 32;
   localparam int HUB75_HEIGHT     = 16;
   localparam int HUB75_COLOR_BITS = 4;

   // Channel slot inside a packed pixel, counted from the LSB: {R,G,B}.
   localparam int RGB_R = 2;
   localparam int RGB_G = 1;
   localparam int RGB_B = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PENDING,
      ST_CLEAR
   } fb_state_t;

endpackage

// File: rtl/hub75_fb_bank.sv
// One half-panel pixel store: single write port and a registered read port,
// written so that it maps onto a simple dual-port block RAM.
module hub75_fb_bank #(
   parameter int DEPTH = 256,
   parameter int DW    = 12
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DW-1:0]            wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DW-1:0]            rdata
);

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rdata_reg;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata_reg <= mem[raddr];
   end

   assign rdata = rdata_reg;

endmodule

// File: rtl/hub75_frame_buffer.sv
// Double-buffered HUB75 frame store with frame-synchronous swap and bit-plane reads.
// Define HUB75_FB_CLEAR_EN to zero the new back buffer after every swap.
module hub75_frame_buffer
   import hub75_pkg::*;
#(
   parameter int WIDTH      = HUB75_WIDTH,
   parameter int HEIGHT     = HUB75_HEIGHT,
   parameter int COLOR_BITS = HUB75_COLOR_BITS
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [4:0]              wr_x,
   input  logic [3:0]              wr_y,
   input  logic [3*COLOR_BITS-1:0] wr_rgb,
   input  logic                    swap_req,
   output logic                    swap_ack,
   input  logic                    frame_end,
   input  logic                    rd_en,
   input  logic [2:0]              rd_row,
   input  logic [4:0]              rd_col,
   input  logic [1:0]              rd_plane,
   output logic                    rd_valid,
   output logic [2:0]              rgb0,
   output logic [2:0]              rgb1
);

   localparam int HALF  = HEIGHT / 2;
   localparam int DEPTH = HALF * WIDTH;
   localparam int AW    = $clog2(DEPTH);
   localparam int RW    = $clog2(HALF);
   localparam int DW    = 3 * COLOR_BITS;

`ifdef HUB75_FB_CLEAR_EN
   localparam bit CLEAR_EN = 1'b1;
`else
   localparam bit CLEAR_EN = 1'b0;
`endif

   fb_state_t      state_reg, state_next;
   logic           swap_fire;
   logic           front_sel_reg;
   logic           swap_ack_reg;
   logic           wr_ready_reg;
   logic [AW-1:0]  clr_addr_reg;
   logic           rd_valid_reg;
   logic           rd_sel_reg;
   logic [1:0]     rd_plane_reg;

   always_comb begin
      state_next = state_reg;
      swap_fire  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (swap_req && frame_end) begin
               swap_fire = 1'b1;
            end else if (swap_req) begin
               state_next = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (frame_end) begin
               swap_fire = 1'b1;
            end
         end
         ST_CLEAR: begin
            if (clr_addr_reg == AW'(DEPTH - 1)) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
      if (swap_fire) begin
         state_next = CLEAR_EN ? ST_CLEAR : ST_IDLE;
      end
   end

   // Writer is held off for the ack cycle so it sees the new back buffer settled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         front_sel_reg <= 1'b0;
         swap_ack_reg  <= 1'b0;
         wr_ready_reg  <= 1'b0;
         clr_addr_reg  <= '0;
         rd_valid_reg  <= 1'b0;
         rd_sel_reg    <= 1'b0;
         rd_plane_reg  <= 2'd0;
      end else begin
         state_reg    <= state_next;
         swap_ack_reg <= swap_fire;
         wr_ready_reg <= (state_next == ST_IDLE) && !swap_fire;
         if (swap_fire) begin
            front_sel_reg <= !front_sel_reg;
         end
         clr_addr_reg <= (state_reg == ST_CLEAR) ? clr_addr_reg + AW'(1) : '0;
         rd_valid_reg <= rd_en;
         if (rd_en) begin
            rd_sel_reg   <= front_sel_reg;
            rd_plane_reg <= rd_plane;
         end
      end
   end

   logic          clearing;
   logic          wr_acc;
   logic          wr_upper;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;
   logic [AW-1:0] bank_addr;
   logic [DW-1:0] bank_wdata;
   logic [3:0]    bank_we;
   logic [DW-1:0] bank_rdata [4];

   assign clearing   = (state_reg == ST_CLEAR);
   assign wr_acc     = wr_valid && wr_ready_reg;
   assign wr_upper   = int'(wr_y) < HALF;
   assign wr_addr    = AW'(wr_y[RW-1:0]) * AW'(WIDTH) + AW'(wr_x);
   assign rd_addr    = AW'(rd_row) * AW'(WIDTH) + AW'(rd_col);
   assign bank_addr  = clearing ? clr_addr_reg : wr_addr;
   assign bank_wdata = clearing ? '0 : wr_rgb;

   // Bank index = {buffer, lower-half}; only the back buffer ever takes writes.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_bank
         localparam bit BUF_ID = (gi / 2) == 1;
         localparam bit UPPER  = (gi % 2) == 0;

         assign bank_we[gi] = (BUF_ID != front_sel_reg) &&
                              (clearing || (wr_acc && (wr_upper == UPPER)));

         hub75_fb_bank #(
            .DEPTH (DEPTH),
            .DW    (DW)
         ) u_bank (
            .clk   (clk),
            .we    (bank_we[gi]),
            .waddr (bank_addr),
            .wdata (bank_wdata),
            .raddr (rd_addr),
            .rdata (bank_rdata[gi])
         );
      end
   endgenerate

   function automatic logic [2:0] plane_of(input logic [DW-1:0] pix, input logic [1:0] p);
      logic [COLOR_BITS-1:0] r, g, b;
      r = pix[RGB_R*COLOR_BITS +: COLOR_BITS];
      g = pix[RGB_G*COLOR_BITS +: COLOR_BITS];
      b = pix[RGB_B*COLOR_BITS +: COLOR_BITS];
      return {r[p], g[p], b[p]};
   endfunction

   assign rd_valid = rd_valid_reg;
   assign rgb0     = rd_valid_reg ? plane_of(bank_rdata[{rd_sel_reg, 1'b0}], rd_plane_reg) : 3'b000;
   assign rgb1     = rd_valid_reg ? plane_of(bank_rdata[{rd_sel_reg, 1'b1}], rd_plane_reg) : 3'b000;
   assign swap_ack = swap_ack_reg;
   assign wr_ready = wr_ready_reg;

endmodule

// File: tb/tb_hub75_frame_buffer.sv
// Directed bench for hub75_frame_buffer: pixel model plus a read-response scoreboard.
module tb_hub75_frame_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_valid;
   logic        wr_ready;
   logic [4:0]  wr_x;
   logic [3:0]  wr_y;
   logic [11:0] wr_rgb;
   logic        swap_req;
   logic        swap_ack;
   logic        frame_end;
   logic        rd_en;
   logic [2:0]  rd_row;
   logic [4:0]  rd_col;
   logic [1:0]  rd_plane;
   logic        rd_valid;
   logic [2:0]  rgb0;
   logic [2:0]  rgb1;

   hub75_frame_buffer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_x      (wr_x),
      .wr_y      (wr_y),
      .wr_rgb    (wr_rgb),
      .swap_req  (swap_req),
      .swap_ack  (swap_ack),
      .frame_end (frame_end),
      .rd_en     (rd_en),
      .rd_row    (rd_row),
      .rd_col    (rd_col),
      .rd_plane  (rd_plane),
      .rd_valid  (rd_valid),
      .rgb0      (rgb0),
      .rgb1      (rgb1)
   );

   always #5 clk = ~clk;

`ifdef HUB75_FB_CLEAR_EN
   localparam int LOW_CYC = 256;
`else
   localparam int LOW_CYC = 1;
`endif

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference picture: [buffer][panel row][column], {R,G,B} nibbles.
   logic [11:0] mdl [2][16][32];
   bit          mfront = 1'b0;

   typedef struct {
      logic [2:0] e0;
      logic [2:0] e1;
      int         due;
   } rd_exp_t;

   rd_exp_t sb [$];
   rd_exp_t mon_e;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] pbits(input logic [11:0] pix, input logic [1:0] p);
      logic [3:0] r, g, b;
      r = pix[11:8];
      g = pix[7:4];
      b = pix[3:0];
      return {r[p], g[p], b[p]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_back_model();
`ifdef HUB75_FB_CLEAR_EN
      for (int y = 0; y < 16; y++)
         for (int x = 0; x < 32; x++)
            mdl[!mfront][y][x] = 12'h000;
`endif
   endtask

   task automatic write_px(input int x, input int y, input logic [11:0] rgb, input bit verbose);
      chk("wr_ready_write", {31'd0, wr_ready}, 32'd1);
      wr_valid = 1'b1;
      wr_x     = 5'(x);
      wr_y     = 4'(y);
      wr_rgb   = rgb;
      tick();
      wr_valid = 1'b0;
      mdl[!mfront][y][x] = rgb;
      if (verbose) $display("write x=%0d y=%0d rgb=%03h buffer=%0d", x, y, rgb, !mfront);
   endtask

   task automatic read_px(input int row, input int col, input int p);
      rd_exp_t e;
      e.e0  = pbits(mdl[mfront][row][col], 2'(p));
      e.e1  = pbits(mdl[mfront][row + 8][col], 2'(p));
      e.due = cyc + 1;
      sb.push_back(e);
      rd_en    = 1'b1;
      rd_row   = 3'(row);
      rd_col   = 5'(col);
      rd_plane = 2'(p);
      tick();
      rd_en = 1'b0;
      $display("read row=%0d col=%0d plane=%0d expect rgb0=%03b rgb1=%03b", row, col, p, e.e0, e.e1);
   endtask

   task automatic fill_back();
      for (int y = 0; y < 16; y++)
         for (int x = 0; x < 32; x++)
            write_px(x, y, 12'($urandom), 1'b0);
      $display("fill buffer=%0d with random pixels", !mfront);
   endtask

   // hold=0: swap_req and frame_end on the same edge; otherwise pending for hold cycles.
   task automatic swap(input int hold, input bit do_wr, input int x, input int y, input logic [11:0] rgb);
      int n;
      if (do_wr) begin
         chk("wr_ready_pre_swap", {31'd0, wr_ready}, 32'd1);
         wr_valid = 1'b1;
         wr_x     = 5'(x);
         wr_y     = 4'(y);
         wr_rgb   = rgb;
      end
      swap_req  = 1'b1;
      frame_end = (hold == 0);
      tick();
      swap_req  = 1'b0;
      frame_end = 1'b0;
      wr_valid  = 1'b0;
      if (do_wr) mdl[!mfront][y][x] = rgb;
      for (int i = 0; i < hold; i++) begin
         chk("ready_pending", {31'd0, wr_ready}, 32'd0);
         chk("ack_pending", {31'd0, swap_ack}, 32'd0);
         if (i == hold / 2) swap_req = 1'b1;
         if (i % 25 == 5) read_px(i % 8, i % 32, i % 4);
         else tick();
         swap_req = 1'b0;
      end
      if (hold != 0) begin
         frame_end = 1'b1;
         tick();
         frame_end = 1'b0;
      end
      chk("swap_ack", {31'd0, swap_ack}, 32'd1);
      mfront = !mfront;
      clear_back_model();
      n = 0;
      while (wr_ready !== 1'b1 && n < 1000) begin
         n++;
         tick();
         if (n == 1) chk("ack_one_cycle", {31'd0, swap_ack}, 32'd0);
      end
      chk("ready_low_cycles", n, LOW_CYC);
      $display("swap hold=%0d front=%0d ready_low=%0d", hold, mfront, n);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
      chk("rst_swap_ack", {31'd0, swap_ack}, 32'd0);
      chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("rst_rgb", {26'd0, rgb0, rgb1}, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("release_wr_ready", {31'd0, wr_ready}, 32'd1);
      chk("release_swap_ack", {31'd0, swap_ack}, 32'd0);
      mfront = 1'b0;
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
      chk("no_ack_after_reset", {31'd0, swap_ack}, 32'd0);
      $display("reset done front=0");
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (rd_valid) begin
            if (sb.size() == 0) begin
               chk("rd_spurious", 32'd1, 32'd0);
            end else begin
               mon_e = sb.pop_front();
               chk("rgb0", {29'd0, rgb0}, {29'd0, mon_e.e0});
               chk("rgb1", {29'd0, rgb1}, {29'd0, mon_e.e1});
               chk("rd_latency", cyc, mon_e.due);
            end
         end else begin
            chk("rd_idle_zero", {26'd0, rgb0, rgb1}, 32'd0);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      wr_valid  = 1'b0;
      wr_x      = 5'd0;
      wr_y      = 4'd0;
      wr_rgb    = 12'h000;
      swap_req  = 1'b0;
      frame_end = 1'b0;
      rd_en     = 1'b0;
      rd_row    = 3'd0;
      rd_col    = 5'd0;
      rd_plane  = 2'd0;
      do_reset();
      mon_en = 1'b1;

      fill_back();
      swap(3, 1'b0, 0, 0, 12'h000);
      fill_back();
      swap(3, 1'b0, 0, 0, 12'h000);

      write_px(3, 2, 12'hF0A, 1'b1);
      swap(3, 1'b0, 0, 0, 12'h000);
      for (int p = 0; p < 4; p++) read_px(2, 3, p);

      write_px(0, 10, 12'hFFF, 1'b1);
      write_px(0, 2, 12'h000, 1'b1);
      swap(3, 1'b0, 0, 0, 12'h000);
      read_px(2, 0, 0);

      swap(100, 1'b0, 0, 0, 12'h000);
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
      chk("ignored_frame_end", {31'd0, swap_ack}, 32'd0);
      tick();
      chk("ignored_frame_end_ack", {31'd0, swap_ack}, 32'd0);
      chk("ready_after_swap", {31'd0, wr_ready}, 32'd1);
      read_px(2, 3, 1);

      swap(0, 1'b1, 5, 12, 12'h123);
      read_px(4, 5, 0);
      read_px(4, 5, 1);

      swap(3, 1'b0, 0, 0, 12'h000);
      swap(3, 1'b0, 0, 0, 12'h000);
      read_px(2, 3, 3);
      read_px(4, 5, 0);
      read_px(7, 31, 2);

      swap(3, 1'b0, 0, 0, 12'h000);
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      repeat (5) tick();
      do_reset();
      read_px(2, 3, 0);
      read_px(4, 5, 0);

`ifdef HUB75_FB_CLEAR_EN
      swap(3, 1'b0, 0, 0, 12'h000);
      swap_req  = 1'b1;
      frame_end = 1'b1;
      tick();
      swap_req  = 1'b0;
      frame_end = 1'b0;
      chk("swap_ack_mid_clear", {31'd0, swap_ack}, 32'd1);
      mfront = !mfront;
      repeat (50) tick();
      chk("ready_mid_clear", {31'd0, wr_ready}, 32'd0);
      do_reset();
      read_px(2, 3, 0);
      read_px(7, 31, 3);
`endif

      repeat (3) tick();
      chk("sb_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
